// File: rtl/peripheral_io_pkg.sv
// rtl/peripheral_io_pkg.sv - command/response encodings and status word layout
package peripheral_io_pkg;

    localparam logic [1:0] CMD_NOP    = 2'b00;
    localparam logic [1:0] CMD_WRITE  = 2'b01;
    localparam logic [1:0] CMD_READ   = 2'b10;
    localparam logic [1:0] CMD_STATUS = 2'b11;

    localparam logic [1:0] RSP_NONE = 2'b00;
    localparam logic [1:0] RSP_ACK  = 2'b01;
    localparam logic [1:0] RSP_DATA = 2'b10;
    localparam logic [1:0] RSP_ERR  = 2'b11;

    localparam int STATUS_TX_LSB  = 0;
    localparam int STATUS_RX_LSB  = 8;
    localparam int STATUS_ERR_LSB = 16;

endpackage

// File: rtl/peripheral_io_responder_sync_fifo.sv
// rtl/peripheral_io_responder_sync_fifo.sv - single-clock FIFO with level and head outputs
module sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_BITS = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_BITS:0]   level,
    output logic [DATA_WIDTH-1:0] head
);

    localparam int DEPTH = 1 << DEPTH_BITS;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr;

    // Callers gate push with !full and pop with !empty.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign full  = (level == (DEPTH_BITS+1)'(DEPTH));
    assign empty = (level == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/peripheral_io_responder.sv
// rtl/peripheral_io_responder.sv - core command decode, registered response, TX/RX FIFOs, error counter
module peripheral_io_responder
    import peripheral_io_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int FIFO_DEPTH_BITS = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            to_peripheral,
    input  logic [DATA_WIDTH-1:0] to_peripheral_data,
    input  logic                  to_peripheral_valid,
    output logic [1:0]            from_peripheral,
    output logic [DATA_WIDTH-1:0] from_peripheral_data,
    output logic                  from_peripheral_valid,
    output logic [DATA_WIDTH-1:0] host_tx_data,
    output logic                  host_tx_valid,
    input  logic                  host_tx_ready,
    input  logic [DATA_WIDTH-1:0] host_rx_data,
    input  logic                  host_rx_valid,
    output logic                  host_rx_ready
);

    logic                     tx_full, tx_empty, rx_full, rx_empty;
    logic [FIFO_DEPTH_BITS:0] tx_level, rx_level;
    logic [DATA_WIDTH-1:0]    rx_head;
    logic                     is_write, is_read;
    logic                     tx_push, tx_pop, rx_push, rx_pop;

    logic [1:0]            rsp_code_d, rsp_code_q;
    logic [DATA_WIDTH-1:0] rsp_data_d, rsp_data_q;
    logic                  rsp_valid_d, rsp_valid_q;
    logic                  err_inc;
    logic [7:0]            err_count;
    logic [DATA_WIDTH-1:0] status_word;

    assign is_write = to_peripheral_valid && (to_peripheral == CMD_WRITE);
    assign is_read  = to_peripheral_valid && (to_peripheral == CMD_READ);
    assign tx_push  = is_write && !tx_full;
    assign tx_pop   = host_tx_ready && !tx_empty;
    assign rx_push  = host_rx_valid && !rx_full;
    assign rx_pop   = is_read && !rx_empty;

    sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH_BITS(FIFO_DEPTH_BITS)) u_tx_fifo (
        .clock(clock), .reset(reset),
        .push(tx_push), .push_data(to_peripheral_data), .pop(tx_pop),
        .full(tx_full), .empty(tx_empty), .level(tx_level), .head(host_tx_data)
    );

    sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH_BITS(FIFO_DEPTH_BITS)) u_rx_fifo (
        .clock(clock), .reset(reset),
        .push(rx_push), .push_data(host_rx_data), .pop(rx_pop),
        .full(rx_full), .empty(rx_empty), .level(rx_level), .head(rx_head)
    );

    always_comb begin
        status_word = '0;
        status_word[STATUS_TX_LSB  +: 8] = 8'(tx_level);
        status_word[STATUS_RX_LSB  +: 8] = 8'(rx_level);
        status_word[STATUS_ERR_LSB +: 8] = err_count;
    end

    // Full/empty decisions use pre-edge state, so a same-cycle host pop or push never rescues a command.
    always_comb begin
        rsp_code_d  = RSP_NONE;
        rsp_data_d  = '0;
        rsp_valid_d = 1'b0;
        err_inc     = 1'b0;
        if (to_peripheral_valid) begin
            rsp_valid_d = 1'b1;
            case (to_peripheral)
                CMD_WRITE: begin
                    rsp_code_d = tx_full ? RSP_ERR : RSP_ACK;
                    err_inc    = tx_full;
                end
                CMD_READ: begin
                    if (rx_empty) begin
                        rsp_code_d = RSP_ERR;
                        err_inc    = 1'b1;
                    end else begin
                        rsp_code_d = RSP_DATA;
                        rsp_data_d = rx_head;
                    end
                end
                CMD_STATUS: begin
                    rsp_code_d = RSP_DATA;
                    rsp_data_d = status_word;
                end
                default: rsp_code_d = RSP_ACK;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rsp_code_q  <= RSP_NONE;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            err_count   <= '0;
        end else begin
            rsp_code_q  <= rsp_code_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            if (err_inc && (err_count != 8'hFF)) err_count <= err_count + 1'b1;
        end
    end

    assign from_peripheral       = rsp_code_q;
    assign from_peripheral_data  = rsp_data_q;
    assign from_peripheral_valid = rsp_valid_q;
    assign host_tx_valid         = !tx_empty;
    assign host_rx_ready         = !rx_full;

endmodule

// File: tb/tb_peripheral_io_responder.sv
// tb/tb_peripheral_io_responder.sv - queue-model scoreboard plus directed literal checks
module tb_peripheral_io_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  to_peripheral;
    logic [31:0] to_peripheral_data;
    logic        to_peripheral_valid;
    logic [1:0]  from_peripheral;
    logic [31:0] from_peripheral_data;
    logic        from_peripheral_valid;
    logic [31:0] host_tx_data;
    logic        host_tx_valid;
    logic        host_tx_ready;
    logic [31:0] host_rx_data;
    logic        host_rx_valid;
    logic        host_rx_ready;

    peripheral_io_responder #(.DATA_WIDTH(32), .FIFO_DEPTH_BITS(3)) dut (
        .clock(clock), .reset(reset),
        .to_peripheral(to_peripheral), .to_peripheral_data(to_peripheral_data),
        .to_peripheral_valid(to_peripheral_valid),
        .from_peripheral(from_peripheral), .from_peripheral_data(from_peripheral_data),
        .from_peripheral_valid(from_peripheral_valid),
        .host_tx_data(host_tx_data), .host_tx_valid(host_tx_valid), .host_tx_ready(host_tx_ready),
        .host_rx_data(host_rx_data), .host_rx_valid(host_rx_valid), .host_rx_ready(host_rx_ready)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    bit chk = 1'b0;

    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];
    int          m_err;
    int          pt, pr;
    bit          bump;
    logic        exp_valid;
    logic [1:0]  exp_code;
    logic [31:0] exp_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Behavioural model: encodings are 00 NOP/none, 01 WRITE/ACK, 10 READ/DATA, 11 STATUS/ERR.
    always @(posedge clock) begin
        if (!reset) begin
            tx_q.delete();
            rx_q.delete();
            m_err     = 0;
            exp_valid = 1'b0;
            exp_code  = 2'b00;
            exp_data  = '0;
        end else begin
            pt = tx_q.size();
            pr = rx_q.size();
            exp_valid = 1'b0;
            exp_code  = 2'b00;
            exp_data  = '0;
            bump      = 1'b0;
            if (host_tx_ready && pt > 0) void'(tx_q.pop_front());
            if (to_peripheral_valid) begin
                exp_valid = 1'b1;
                case (to_peripheral)
                    2'b00: exp_code = 2'b01;
                    2'b01: begin
                        if (pt < 8) begin
                            tx_q.push_back(to_peripheral_data);
                            exp_code = 2'b01;
                        end else begin
                            exp_code = 2'b11;
                            bump = 1'b1;
                        end
                    end
                    2'b10: begin
                        if (pr > 0) begin
                            exp_code = 2'b10;
                            exp_data = rx_q.pop_front();
                        end else begin
                            exp_code = 2'b11;
                            bump = 1'b1;
                        end
                    end
                    default: begin
                        exp_code = 2'b10;
                        exp_data = 32'(m_err * 65536 + pr * 256 + pt);
                    end
                endcase
            end
            if (host_rx_valid && pr < 8) rx_q.push_back(host_rx_data);
            if (bump && m_err < 255) m_err++;
            assert (tx_q.size() <= 8 && rx_q.size() <= 8)
            else begin
                fails++;
                $display("FAIL fifo_bounds: tx %0d rx %0d, expected <= 8", tx_q.size(), rx_q.size());
            end
        end
    end

    always @(negedge clock) begin
        if (chk) begin
            check("rsp_valid", 32'(from_peripheral_valid), 32'(exp_valid));
            check("rsp_code", 32'(from_peripheral), 32'(exp_code));
            check("rsp_data", from_peripheral_data, exp_data);
            check("tx_valid", 32'(host_tx_valid), 32'(tx_q.size() != 0));
            if (tx_q.size() != 0) check("tx_data", host_tx_data, tx_q[0]);
            check("rx_ready", 32'(host_rx_ready), 32'(rx_q.size() < 8));
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic do_cmd(input logic [1:0] c, input logic [31:0] d);
        to_peripheral       = c;
        to_peripheral_data  = d;
        to_peripheral_valid = 1'b1;
        step();
        to_peripheral_valid = 1'b0;
        to_peripheral       = 2'b00;
        to_peripheral_data  = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic expect_rsp(input string name, input logic [1:0] code, input logic [31:0] data);
        check({name, "_valid"}, 32'(from_peripheral_valid), 32'd1);
        check({name, "_code"}, 32'(from_peripheral), 32'(code));
        check({name, "_data"}, from_peripheral_data, data);
    endtask

    initial begin
        reset = 1'b0;
        to_peripheral = 2'b00;
        to_peripheral_data = '0;
        to_peripheral_valid = 1'b0;
        host_tx_ready = 1'b0;
        host_rx_data = '0;
        host_rx_valid = 1'b0;
        step();
        step();
        chk = 1'b1;
        reset = 1'b1;

        check("reset_tx_valid", 32'(host_tx_valid), 32'd0);
        check("reset_rx_ready", 32'(host_rx_ready), 32'd1);
        check("reset_rsp_valid", 32'(from_peripheral_valid), 32'd0);
        do_cmd(2'b11, '0);
        expect_rsp("status_empty", 2'b10, 32'h0000_0000);

        do_cmd(2'b01, 32'hDEAD_BEEF);
        expect_rsp("write1", 2'b01, 32'h0);
        do_cmd(2'b01, 32'h0000_1000);
        expect_rsp("write2", 2'b01, 32'h0);
        do_cmd(2'b11, '0);
        expect_rsp("status_tx2", 2'b10, 32'h0000_0002);
        host_tx_ready = 1'b1;
        check("tx_head0", host_tx_data, 32'hDEAD_BEEF);
        step();
        check("tx_head1", host_tx_data, 32'h0000_1000);
        step();
        check("tx_drained", 32'(host_tx_valid), 32'd0);
        host_tx_ready = 1'b0;

        host_rx_data = 32'h8000_0000;
        host_rx_valid = 1'b1;
        step();
        host_rx_valid = 1'b0;
        do_cmd(2'b10, '0);
        expect_rsp("read_ok", 2'b10, 32'h8000_0000);
        do_cmd(2'b10, '0);
        expect_rsp("read_empty", 2'b11, 32'h0);
        do_cmd(2'b11, '0);
        expect_rsp("status_err1", 2'b10, 32'h0001_0000);

        host_rx_valid = 1'b1;
        host_rx_data = 32'hA1;
        step();
        host_rx_data = 32'hA2;
        step();
        host_rx_data = 32'hA3;
        do_cmd(2'b10, '0);
        host_rx_valid = 1'b0;
        expect_rsp("read_with_push", 2'b10, 32'h0000_00A1);
        do_cmd(2'b11, '0);
        expect_rsp("status_rx2", 2'b10, 32'h0001_0200);
        do_cmd(2'b00, '0);
        expect_rsp("nop", 2'b01, 32'h0);

        do_reset();
        for (int i = 0; i < 9; i++) begin
            do_cmd(2'b01, 32'h100 + 32'(i));
            check("fill_code", 32'(from_peripheral), (i < 8) ? 32'd1 : 32'd3);
        end
        do_cmd(2'b11, '0);
        expect_rsp("status_full", 2'b10, 32'h0001_0008);
        host_tx_ready = 1'b1;
        do_cmd(2'b01, 32'h999);
        host_tx_ready = 1'b0;
        expect_rsp("write_full_pop", 2'b11, 32'h0);
        do_cmd(2'b11, '0);
        expect_rsp("status_tx7", 2'b10, 32'h0002_0007);
        check("tx_head_after_pop", host_tx_data, 32'h101);

        do_reset();
        for (int i = 0; i < 300; i++) do_cmd(2'b10, '0);
        expect_rsp("read_300", 2'b11, 32'h0);
        do_cmd(2'b11, '0);
        expect_rsp("status_sat", 2'b10, 32'h00FF_0000);
        host_rx_valid = 1'b1;
        host_rx_data = 32'h55;
        do_cmd(2'b10, '0);
        host_rx_valid = 1'b0;
        expect_rsp("read_empty_push", 2'b11, 32'h0);
        do_cmd(2'b11, '0);
        expect_rsp("status_rx1", 2'b10, 32'h00FF_0100);

        for (int i = 0; i < 3; i++) do_cmd(2'b01, 32'h200 + 32'(i));
        reset = 1'b0;
        do_cmd(2'b01, 32'h300);
        check("reset_drop_valid", 32'(from_peripheral_valid), 32'd0);
        check("reset_drop_tx", 32'(host_tx_valid), 32'd0);
        reset = 1'b1;
        do_cmd(2'b11, '0);
        expect_rsp("status_after_reset", 2'b10, 32'h0000_0000);
        check("tx_valid_after_reset", 32'(host_tx_valid), 32'd0);

        step();
        chk = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
